mem_access_stage: RTL and testbench

- MIPS memory stage plus MEM/WB pipeline register.
- Performs loads and stores against an internal word-organised data RAM.
- Registers load data, ALU result and writeback control into the write-back stage inputs (read_data, alu_result, mem_to_reg) plus destination register and reg_write.
- Sits between the EX/MEM register and write_back, and adds stall, flush and misalignment handling.

---
 rtl/mips_pkg.sv | 18 +
 rtl/data_ram.sv | 25 ++
 rtl/mem_access_stage.sv | 137 +++++++++++++
 tb/tb_mem_access_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage: load/store size encodings and datapath widths.
package mips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] MEM_WORD  = 3'b000;
  localparam logic [2:0] MEM_BYTE  = 3'b001;
  localparam logic [2:0] MEM_HALF  = 3'b010;
  localparam logic [2:0] MEM_BYTEU = 3'b101;
  localparam logic [2:0] MEM_HALFU = 3'b110;

  // Access size lives in mem_op[1:0]; mem_op[2] selects zero (1) or sign (0) extension.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

endpackage

// File: rtl/data_ram.sv
// Word-organised data RAM with per-byte write enables and an asynchronous read port.
module data_ram
  import mips_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [3:0]        byte_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory stage: load/store against data_ram, lane extraction and extension,
// misalignment detection, and the MEM/WB pipeline register with stall/flush.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            mem_op,
  input  logic [WORD_W-1:0]     alu_result_in,
  input  logic [WORD_W-1:0]     write_data_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  output logic [WORD_W-1:0]     read_data,
  output logic [WORD_W-1:0]     alu_result,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic                  reg_write,
  output logic                  mem_to_reg,
  output logic                  misaligned
);

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [1:0]        size;
  logic              zero_ext;
  logic              mem_access;
  logic              misalign_c;
  logic              store_commit;
  logic [3:0]        byte_en;
  logic [3:0]        store_mask;
  logic [WORD_W-1:0] store_data;
  logic [WORD_W-1:0] ram_rdata;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [WORD_W-1:0] load_ext;
  logic [WORD_W-1:0] read_data_d;

  assign word_idx   = alu_result_in[ADDR_W+1:2];
  assign lane       = alu_result_in[1:0];
  assign size       = mem_op[1:0];
  assign zero_ext   = mem_op[2];
  assign mem_access = mem_read | mem_write;

  // Encoding 2'b11 in the size field is unused and behaves as a word access.
  always_comb begin
    misalign_c = 1'b0;
    if (mem_access) begin
      case (size)
        SZ_BYTE: misalign_c = 1'b0;
        SZ_HALF: misalign_c = lane[0];
        default: misalign_c = (lane != 2'b00);
      endcase
    end
  end

  always_comb begin
    store_mask = 4'b1111;
    store_data = write_data_in;
    case (size)
      SZ_BYTE: begin
        store_mask = 4'b0001 << lane;
        store_data = {4{write_data_in[7:0]}};
      end
      SZ_HALF: begin
        store_mask = lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{write_data_in[15:0]}};
      end
      default: begin
        store_mask = 4'b1111;
        store_data = write_data_in;
      end
    endcase
  end

  assign store_commit = mem_write & ~misalign_c & ~stall & ~flush & ~rst;
  assign byte_en      = store_commit ? store_mask : 4'b0000;

  data_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_data_ram (
    .clk     (clk),
    .byte_en (byte_en),
    .addr    (word_idx),
    .wdata   (store_data),
    .rdata   (ram_rdata)
  );

  always_comb begin
    byte_sel = ram_rdata[7:0];
    case (lane)
      2'd0:    byte_sel = ram_rdata[7:0];
      2'd1:    byte_sel = ram_rdata[15:8];
      2'd2:    byte_sel = ram_rdata[23:16];
      default: byte_sel = ram_rdata[31:24];
    endcase
    half_sel = lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
  end

  always_comb begin
    load_ext = ram_rdata;
    case (size)
      SZ_BYTE: load_ext = {{24{~zero_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_ext = {{16{~zero_ext & half_sel[15]}}, half_sel};
      default: load_ext = ram_rdata;
    endcase
  end

  // A store wins over a simultaneous read, so only a pure, aligned load returns data.
  assign read_data_d = (mem_read & ~mem_write & ~misalign_c) ? load_ext : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      read_data  <= '0;
      alu_result <= '0;
      write_reg  <= '0;
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      misaligned <= 1'b0;
    end else if (!stall) begin
      read_data  <= read_data_d;
      alu_result <= alu_result_in;
      write_reg  <= write_reg_in;
      reg_write  <= reg_write_in & ~misalign_c;
      mem_to_reg <= mem_to_reg_in;
      misaligned <= misalign_c;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, hand sequences, and randomized
// traffic checked against a byte-addressed reference model.
module tb_mem_access_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush, mem_read, mem_write, reg_write_in, mem_to_reg_in;
  logic [2:0]  mem_op;
  logic [31:0] alu_result_in, write_data_in;
  logic [4:0]  write_reg_in;
  logic [31:0] read_data, alu_result;
  logic [4:0]  write_reg;
  logic        reg_write, mem_to_reg, misaligned;

  always #5 clk = ~clk;

  mem_access_stage #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_read(mem_read), .mem_write(mem_write), .mem_op(mem_op),
    .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .write_reg_in(write_reg_in), .reg_write_in(reg_write_in),
    .mem_to_reg_in(mem_to_reg_in),
    .read_data(read_data), .alu_result(alu_result), .write_reg(write_reg),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .misaligned(misaligned)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference model: memory as 4 KiB of bytes (addresses wrap modulo DEPTH*4).
  logic [7:0]  mb [4096];
  logic [31:0] m_rd, m_alu;
  logic [4:0]  m_wreg;
  logic        m_rw, m_m2r, m_mis, m_rc;

  function automatic logic [31:0] model_load(input logic [11:0] a, input logic [2:0] op);
    logic [11:0] b;
    logic [15:0] h;
    b = {a[11:2], 2'b00};
    h = {mb[12'(a + 12'd1)], mb[a]};
    case (op[1:0])
      2'b01:   return op[2] ? {24'h0, mb[a]} : {{24{mb[a][7]}}, mb[a]};
      2'b10:   return op[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: return {mb[12'(b + 12'd3)], mb[12'(b + 12'd2)], mb[12'(b + 12'd1)], mb[b]};
    endcase
  endfunction

  task automatic model_step;
    logic [11:0] a;
    logic [1:0]  sz;
    logic        mis;
    logic [31:0] ld;
    a   = alu_result_in[11:0];
    sz  = mem_op[1:0];
    mis = (mem_read || mem_write) &&
          ((sz == 2'b10) ? a[0] : (sz == 2'b01) ? 1'b0 : (a[1:0] != 2'b00));
    ld  = model_load(a, mem_op);
    if (!rst && !stall && !flush && mem_write && !mis) begin
      case (sz)
        2'b01: mb[a] = write_data_in[7:0];
        2'b10: begin
          mb[a] = write_data_in[7:0];
          mb[12'(a + 12'd1)] = write_data_in[15:8];
        end
        default: for (int k = 0; k < 4; k++) mb[12'(a + 12'(k))] = write_data_in[8*k +: 8];
      endcase
    end
    if (rst || flush) begin
      m_rd = 0; m_alu = 0; m_wreg = 0; m_rw = 0; m_m2r = 0; m_mis = 0; m_rc = 1;
    end else if (!stall) begin
      m_rd   = (mem_read && !mem_write && !mis) ? ld : 32'h0;
      m_rc   = (mem_read && !mem_write) || mis;
      m_alu  = alu_result_in;
      m_wreg = write_reg_in;
      m_rw   = reg_write_in && !mis;
      m_m2r  = mem_to_reg_in;
      m_mis  = mis;
    end
  endtask

  task automatic drv(input int r, input int s, input int f, input int rd, input int wr,
                     input int op, input logic [31:0] addr, input logic [31:0] wd,
                     input int wreg, input int rw, input int m2r);
    rst = r[0]; stall = s[0]; flush = f[0]; mem_read = rd[0]; mem_write = wr[0];
    mem_op = op[2:0]; alu_result_in = addr; write_data_in = wd;
    write_reg_in = wreg[4:0]; reg_write_in = rw[0]; mem_to_reg_in = m2r[0];
  endtask

  task automatic step;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cmp_model(input string tag);
    if (m_rc) chk({tag, ".read_data"}, read_data, m_rd);
    chk({tag, ".alu_result"}, alu_result, m_alu);
    chk({tag, ".write_reg"}, {27'h0, write_reg}, {27'h0, m_wreg});
    chk({tag, ".reg_write"}, {31'h0, reg_write}, {31'h0, m_rw});
    chk({tag, ".mem_to_reg"}, {31'h0, mem_to_reg}, {31'h0, m_m2r});
    chk({tag, ".misaligned"}, {31'h0, misaligned}, {31'h0, m_mis});
  endtask

  typedef struct packed {
    logic        rst, stall, flush, rd, wr;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic [4:0]  wreg;
    logic        rw, m2r;
    logic        rc;
    logic [31:0] e_rd, e_alu;
    logic [4:0]  e_wreg;
    logic        e_rw, e_m2r, e_mis;
  } vec_t;

  function automatic vec_t v(input int r, input int s, input int f, input int rd, input int wr,
                             input int op, input logic [31:0] addr, input logic [31:0] wd,
                             input int wreg, input int rw, input int m2r, input int rc,
                             input logic [31:0] e_rd, input logic [31:0] e_alu, input int e_wreg,
                             input int e_rw, input int e_m2r, input int e_mis);
    vec_t t;
    t.rst = r[0]; t.stall = s[0]; t.flush = f[0]; t.rd = rd[0]; t.wr = wr[0];
    t.op = op[2:0]; t.addr = addr; t.wdata = wd; t.wreg = wreg[4:0];
    t.rw = rw[0]; t.m2r = m2r[0]; t.rc = rc[0]; t.e_rd = e_rd; t.e_alu = e_alu;
    t.e_wreg = e_wreg[4:0]; t.e_rw = e_rw[0]; t.e_m2r = e_m2r[0]; t.e_mis = e_mis[0];
    return t;
  endfunction

  vec_t vecs[$];

  initial begin
    logic [2:0]  ops [5];
    logic [31:0] addr;
    int          opi;
    ops[0] = MEM_WORD; ops[1] = MEM_BYTE; ops[2] = MEM_HALF; ops[3] = MEM_BYTEU; ops[4] = MEM_HALFU;
    drv(1, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);

    //            rst st fl rd wr op addr          wdata       wr rw m2 rc e_rd          e_alu        ewr erw em em
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 32'h0,      32'h0,       0, 0, 0, 1, 32'h0,        32'h0,        0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 0, 0, 32'h0,      32'h0,       0, 0, 0, 1, 32'h0,        32'h0,        0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 32'h10,     32'hDEADBEEF, 0, 0, 0, 0, 32'h0,       32'h10,       0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 32'h10,     32'h0,       8, 1, 1, 1, 32'hDEADBEEF, 32'h10,       8, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 32'h20,     32'h11223344, 0, 0, 0, 0, 32'h0,       32'h20,       0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 32'h21,     32'hF0,      0, 0, 0, 0, 32'h0,        32'h21,       0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 1, 32'h21,     32'h0,       9, 1, 1, 1, 32'hFFFFFFF0, 32'h21,       9, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 5, 32'h21,     32'h0,       9, 1, 1, 1, 32'h000000F0, 32'h21,       9, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 2, 32'h22,     32'h0,       9, 1, 1, 1, 32'h00001122, 32'h22,       9, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 6, 32'h20,     32'h0,       9, 1, 1, 1, 32'h0000F044, 32'h20,       9, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 32'h30,     32'h30303030, 0, 0, 0, 0, 32'h0,       32'h30,       0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 32'h31,     32'hAAAAAAAA, 0, 1, 0, 1, 32'h0,       32'h31,       0, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 32'h30,     32'h0,       3, 1, 1, 1, 32'h30303030, 32'h30,       3, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 2, 32'h33,     32'h0,       4, 1, 1, 1, 32'h0,        32'h33,       4, 0, 1, 1));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 32'h10,     32'h0,       8, 1, 1, 1, 32'hDEADBEEF, 32'h10,       8, 1, 1, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 1, 0, 0, 1, 0, 32'h10,   32'h55,      0, 0, 0, 1, 32'hDEADBEEF, 32'h10,       8, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 32'h10,     32'h0,       7, 1, 1, 1, 32'hDEADBEEF, 32'h10,       7, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 32'h40,     32'h40404040, 0, 0, 0, 0, 32'h0,       32'h40,       0, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, 0, 1, 0, 32'h40,     32'h12345678, 3, 1, 1, 1, 32'h0,       32'h0,        0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 32'h40,     32'h0,       2, 1, 1, 1, 32'h40404040, 32'h40,       2, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 32'h1010,   32'hCAFEF00D, 0, 0, 0, 0, 32'h0,       32'h1010,     0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 32'h0010,   32'h0,       5, 1, 1, 1, 32'hCAFEF00D, 32'h10,       5, 1, 1, 0));
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 32'h50,     32'h50505050, 0, 0, 0, 0, 32'h0,       32'h50,       0, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 0, 1, 0, 32'h50,     32'h0BADBEEF, 0, 0, 0, 1, 32'h0,       32'h0,        0, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 1, 0, 0, 32'h50,     32'h0,       6, 1, 1, 1, 32'h50505050, 32'h50,       6, 1, 1, 0));
    vecs.push_back(v(1, 1, 0, 1, 0, 0, 32'h50,     32'h0,       6, 1, 1, 1, 32'h0,        32'h0,        0, 0, 0, 0));

    foreach (vecs[i]) begin
      vec_t t;
      string tag;
      t = vecs[i];
      tag = $sformatf("vec%0d", i);
      drv(t.rst, t.stall, t.flush, t.rd, t.wr, t.op, t.addr, t.wdata, t.wreg, t.rw, t.m2r);
      step();
      if (t.rc) chk({tag, ".read_data"}, read_data, t.e_rd);
      chk({tag, ".alu_result"}, alu_result, t.e_alu);
      chk({tag, ".write_reg"}, {27'h0, write_reg}, {27'h0, t.e_wreg});
      chk({tag, ".reg_write"}, {31'h0, reg_write}, {31'h0, t.e_rw});
      chk({tag, ".mem_to_reg"}, {31'h0, mem_to_reg}, {31'h0, t.e_m2r});
      chk({tag, ".misaligned"}, {31'h0, misaligned}, {31'h0, t.e_mis});
    end

    // Half stores touch only their lanes; the word is assembled little-endian.
    drv(0, 0, 0, 0, 1, 0, 32'h60, 32'h0, 0, 0, 0);          step();
    drv(0, 0, 0, 0, 1, 2, 32'h62, 32'h9999BEEF, 0, 0, 0);   step();
    drv(0, 0, 0, 0, 1, 1, 32'h60, 32'h77, 0, 0, 0);         step();
    drv(0, 0, 0, 1, 0, 0, 32'h60, 32'h0, 1, 1, 1);          step();
    chk("half_lane.read_data", read_data, 32'hBEEF0077);
    drv(0, 0, 0, 1, 0, 2, 32'h62, 32'h0, 1, 1, 1);          step();
    chk("half_lane.lh_sign", read_data, 32'hFFFFBEEF);
    drv(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);           step();

    // Give every word in the random window a defined value.
    for (int w = 0; w < 32; w++) begin
      drv(0, 0, 0, 0, 1, 0, 32'(w * 4), $urandom, 0, 0, 0);
      step();
    end

    for (int n = 0; n < 400; n++) begin
      int kind;
      opi  = $urandom_range(0, 4);
      addr = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (ops[opi][1:0] == SZ_WORD) addr[1:0] = 2'b00;
        else if (ops[opi][1:0] == SZ_HALF) addr[0] = 1'b0;
      end
      addr = addr | ($urandom_range(0, 15) << 12);
      kind = $urandom_range(0, 2);
      drv(($urandom_range(0, 29) == 0) ? 1 : 0, ($urandom_range(0, 7) == 0) ? 1 : 0,
          ($urandom_range(0, 9) == 0) ? 1 : 0, (kind == 1) ? 1 : 0, (kind == 2) ? 1 : 0,
          int'(ops[opi]), addr, $urandom, $urandom_range(0, 31), $urandom_range(0, 1),
          (kind == 1) ? 1 : 0);
      step();
      cmp_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
